demux_result_serializer: RTL and testbench

- Reverse-direction companion to the matrix-multiplier input demux.
- Captures NWORDS parallel result words in one cycle and streams them out one word per accepted transfer, in index order 0..NWORDS-1.
- Uses a valid/ready handshake and tags each word with its index, so the downstream consumer can rebuild the matrix layout.
- Sits between the matrix-multiplier result registers and the serial output or host interface.

---
 rtl/demux_result_serializer.sv | 92 +++++++++
 tb/tb_demux_result_serializer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/demux_result_serializer.sv
// Captures NWORDS parallel result words in one cycle and streams them out
// one word per valid/ready handshake, tagged with the word index.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | no frame held; load captures Data_in on the next edge
//   ST_SEND | frame held; word idx_out presented until accepted
module demux_result_serializer #(
   parameter int WIDTH  = 8,
   parameter int NWORDS = 12,
   parameter int IDXW   = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load,
   input  logic [WIDTH*NWORDS-1:0] Data_in,
   output logic [WIDTH-1:0]        Data_out,
   output logic [IDXW-1:0]         idx_out,
   output logic                    valid,
   input  logic                    ready,
   output logic                    busy,
   output logic                    done
);

   typedef enum logic {ST_IDLE, ST_SEND} state_t;

   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NWORDS - 1);

   state_t                             state_q, state_d;
   logic [NWORDS-1:0][WIDTH-1:0]       buf_q, buf_d;
   logic [IDXW-1:0]                    idx_q, idx_d;
   logic [WIDTH-1:0]                   data_q, data_d;
   logic                               done_q, done_d;
   logic [IDXW-1:0]                    idx_nxt;

   assign idx_nxt = idx_q + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         buf_q   <= '0;
         idx_q   <= '0;
         data_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      idx_d   = idx_q;
      data_d  = data_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (load) begin
               buf_d   = Data_in;
               idx_d   = '0;
               data_d  = Data_in[WIDTH-1:0];
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            // load is deliberately not looked at here: it is dropped, not queued
            if (ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d = ST_IDLE;
                  idx_d   = '0;
                  done_d  = 1'b1;
               end else begin
                  idx_d  = idx_nxt;
                  data_d = buf_q[idx_nxt];
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign valid    = (state_q == ST_SEND);
   assign busy     = (state_q == ST_SEND);
   assign done     = done_q;
   assign Data_out = data_q;
   assign idx_out  = idx_q;

endmodule

// File: tb/tb_demux_result_serializer.sv
// Scoreboard bench for demux_result_serializer: directed frames, stalls,
// ignored loads, mid-frame reset, then randomized traffic.
module tb_demux_result_serializer;
   localparam int W = 8;
   localparam int N = 12;
   localparam int IW = 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            load = 1'b0;
   logic [W*N-1:0]  Data_in = '0;
   logic [W-1:0]    Data_out;
   logic [IW-1:0]   idx_out;
   logic            valid;
   logic            ready = 1'b0;
   logic            busy;
   logic            done;

   demux_result_serializer #(.WIDTH(W), .NWORDS(N), .IDXW(IW)) dut (
      .clk(clk), .rst_n(rst_n), .load(load), .Data_in(Data_in),
      .Data_out(Data_out), .idx_out(idx_out), .valid(valid),
      .ready(ready), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [IW-1:0] idx;
      logic [W-1:0]  data;
   } exp_t;

   exp_t       sb_q[$];
   int         model_cnt = 0;   // words of the current frame not yet accepted
   logic       exp_done = 1'b0;
   int         n_checks = 0;
   int         n_fail = 0;

   logic       prev_stall = 1'b0;
   logic [W-1:0]  prev_data = '0;
   logic [IW-1:0] prev_idx = '0;
   logic [W-1:0]  last_data = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [W*N-1:0] frame(input logic [7:0] base);
      logic [W*N-1:0] v;
      v = '0;
      for (int k = 0; k < N; k++) v[k*W +: W] = W'(base + 8'(k));
      return v;
   endfunction

   function automatic logic [W*N-1:0] rand_frame();
      logic [W*N-1:0] v;
      v = '0;
      for (int k = 0; k < N; k++) v[k*W +: W] = W'($urandom_range(0, 255));
      return v;
   endfunction

   // Drive inputs, take one edge, update the reference model from the
   // inputs the DUT saw at that edge.
   task automatic step(input logic l, input logic r, input logic [W*N-1:0] d);
      exp_t e;
      load = l; ready = r; Data_in = d;
      @(posedge clk);
      exp_done = 1'b0;
      if (model_cnt == 0) begin
         if (l) begin
            for (int k = 0; k < N; k++) begin
               e.idx = IW'(k);
               e.data = d[k*W +: W];
               sb_q.push_back(e);
            end
            model_cnt = N;
         end
      end else if (r) begin
         model_cnt--;
         if (model_cnt == 0) exp_done = 1'b1;
      end
      #1;
   endtask

   task automatic drain(input int budget);
      int c;
      c = 0;
      while (model_cnt != 0 && c < budget) begin
         step(1'b0, 1'b1, '0);
         c++;
      end
      chk("drain_timeout", model_cnt, 0);
   endtask

   task automatic check_reset_outputs();
      chk("rst_valid", valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_data", Data_out, 0);
      chk("rst_idx", idx_out, 0);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      load = 1'b0;
      ready = 1'b0;
      #1;
      check_reset_outputs();
      sb_q.delete();
      model_cnt = 0;
      exp_done = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Monitor: compares at mid-cycle, independent of the stimulus
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         chk("valid", valid, (model_cnt > 0));
         chk("busy", busy, (model_cnt > 0));
         chk("done", done, exp_done);
         if (exp_done) begin
            chk("done_data_hold", Data_out, last_data);
            chk("done_idx", idx_out, 0);
         end
         if (prev_stall && valid) begin
            chk("stall_data", Data_out, prev_data);
            chk("stall_idx", idx_out, prev_idx);
         end
         if (valid && ready) begin
            if (sb_q.size() == 0) begin
               chk("sb_underflow", 1, 0);
            end else begin
               e = sb_q.pop_front();
               chk("word_data", Data_out, e.data);
               chk("word_idx", idx_out, e.idx);
               last_data = e.data;
            end
         end
         prev_stall = valid && !ready;
         prev_data  = Data_out;
         prev_idx   = idx_out;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W*N-1:0] f10, fa0, fff;
      f10 = frame(8'h10);
      fa0 = frame(8'hA0);
      fff = {N{8'hFF}};

      // Reset state
      #2;
      check_reset_outputs();
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Full-rate frame
      step(1'b1, 1'b1, f10);
      for (int i = 0; i < N; i++) step(1'b0, 1'b1, f10);
      step(1'b0, 1'b0, f10);
      step(1'b0, 1'b0, f10);

      // Ready pattern 1,0,0,1,...
      step(1'b1, 1'b0, f10);
      for (int i = 0; i < 100 && model_cnt != 0; i++)
         step(1'b0, (i % 4 == 0) || (i % 4 == 3), f10);
      chk("toggle_timeout", model_cnt, 0);
      step(1'b0, 1'b0, f10);

      // Loads during SEND (including the final edge) are ignored
      step(1'b1, 1'b1, f10);
      for (int i = 0; i < N; i++) step(1'b1, 1'b1, fff);
      step(1'b0, 1'b1, fff);
      step(1'b0, 1'b1, fff);

      // Load in the done cycle
      step(1'b1, 1'b1, f10);
      for (int i = 0; i < N; i++) step(1'b0, 1'b1, f10);
      step(1'b1, 1'b0, fa0);
      chk("done_load_valid", valid, 1);
      chk("done_load_data", Data_out, 8'hA0);
      chk("done_load_idx", idx_out, 0);
      drain(50);
      step(1'b0, 1'b0, '0);

      // Mid-frame reset at idx 5
      step(1'b1, 1'b1, f10);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, f10);
      chk("pre_rst_idx", idx_out, 5);
      #2;
      apply_reset();
      step(1'b1, 1'b1, fa0);
      chk("restart_idx", idx_out, 0);
      chk("restart_data", Data_out, 8'hA0);
      drain(50);
      step(1'b0, 1'b0, '0);

      // Long stall on word 3
      step(1'b1, 1'b1, f10);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, f10);
      for (int i = 0; i < 20; i++) step(1'b0, 1'b0, fff);
      chk("stall3_data", Data_out, 8'h13);
      chk("stall3_idx", idx_out, 3);
      drain(50);
      step(1'b0, 1'b0, '0);

      // Random traffic
      for (int i = 0; i < 3000; i++)
         step(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0), rand_frame());
      drain(200);
      step(1'b0, 1'b0, '0);
      step(1'b0, 1'b0, '0);
      chk("sb_leftover", sb_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
